// File: rtl/jacobi_mul_share_arb.sv
// rtl/jacobi_mul_share_arb.sv - round-robin time-share of one pipelined multiplier among stencil requesters
module jacobi_mul_share_arb #(
    parameter int NUM_REQ     = 4,
    parameter int A_WIDTH     = 10,
    parameter int B_WIDTH     = 11,
    parameter int P_WIDTH     = 20,
    parameter int MUL_LATENCY = 3,
    parameter int IDX_W       = $clog2(NUM_REQ)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*A_WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*B_WIDTH-1:0] req_b_i,
    output logic [NUM_REQ-1:0]         rsp_valid_o,
    input  logic [NUM_REQ-1:0]         rsp_ready_i,
    output logic [P_WIDTH-1:0]         rsp_data_o,
    output logic                       mul_ce_o,
    output logic [A_WIDTH-1:0]         mul_din0_o,
    output logic [B_WIDTH-1:0]         mul_din1_o,
    input  logic [P_WIDTH-1:0]         mul_dout_i,
    output logic                       idle_o
);
    localparam int             LAST   = MUL_LATENCY - 1;
    localparam logic [IDX_W:0] NREQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W:0] ONE_W  = (IDX_W+1)'(1);

    logic [MUL_LATENCY-1:0]            tag_valid_q, tag_valid_d;
    logic [MUL_LATENCY-1:0][IDX_W-1:0] tag_idx_q, tag_idx_d;
    logic [IDX_W-1:0]                  rr_q, rr_d;
    logic                              grant_any;
    logic [IDX_W-1:0]                  grant_idx;
    logic [IDX_W:0]                    cand;
    logic [IDX_W:0]                    nxt;
    logic                              stall;

    // The last tag stage lines up with the product on mul_dout_i; an unaccepted result freezes everything.
    always_comb begin
        stall = tag_valid_q[LAST] & ~rsp_ready_i[tag_idx_q[LAST]];
    end

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_q} + (IDX_W+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!grant_any && req_valid_i[cand[IDX_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        mul_ce_o    = ~stall;
        req_ready_o = '0;
        mul_din0_o  = '0;
        mul_din1_o  = '0;
        if (grant_any) begin
            mul_din0_o = req_a_i[int'(grant_idx)*A_WIDTH +: A_WIDTH];
            mul_din1_o = req_b_i[int'(grant_idx)*B_WIDTH +: B_WIDTH];
            if (!stall) begin
                req_ready_o[grant_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        tag_valid_d = tag_valid_q;
        tag_idx_d   = tag_idx_q;
        rr_d        = rr_q;
        nxt         = {1'b0, grant_idx} + ONE_W;
        if (nxt >= NREQ_W) begin
            nxt = '0;
        end
        if (!stall) begin
            tag_valid_d[0] = grant_any;
            tag_idx_d[0]   = grant_idx;
            for (int s = 1; s < MUL_LATENCY; s++) begin
                tag_valid_d[s] = tag_valid_q[s-1];
                tag_idx_d[s]   = tag_idx_q[s-1];
            end
            if (grant_any) begin
                rr_d = nxt[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        if (tag_valid_q[LAST]) begin
            rsp_valid_o[tag_idx_q[LAST]] = 1'b1;
        end
    end

    assign rsp_data_o = mul_dout_i;
    assign idle_o     = ~|tag_valid_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tag_valid_q <= '0;
            tag_idx_q   <= '0;
            rr_q        <= '0;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_idx_q   <= tag_idx_d;
            rr_q        <= rr_d;
        end
    end
endmodule

// File: tb/tb_jacobi_mul_share_arb.sv
// tb/tb_jacobi_mul_share_arb.sv - directed bench for jacobi_mul_share_arb with a ce-gated 3-stage multiplier model
module tb_jacobi_mul_share_arb;
    localparam int NR = 4;
    localparam int AW = 10;
    localparam int BW = 11;
    localparam int PW = 20;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_ready;
    logic [NR*AW-1:0] req_a = '0;
    logic [NR*BW-1:0] req_b = '0;
    logic [NR-1:0]    rsp_valid;
    logic [NR-1:0]    rsp_ready = '1;
    logic [PW-1:0]    rsp_data;
    logic             mul_ce;
    logic [AW-1:0]    mul_din0;
    logic [BW-1:0]    mul_din1;
    logic [PW-1:0]    mul_dout;
    logic             idle;

    logic [AW+BW-1:0] prod;
    logic [PW-1:0]    m0 = '0, m1 = '0, m2 = '0;
    int               pass_cnt = 0;
    int               total_cnt = 0;

    always #5 clk = ~clk;

    jacobi_mul_share_arb dut (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .mul_ce_o(mul_ce), .mul_din0_o(mul_din0), .mul_din1_o(mul_din1),
        .mul_dout_i(mul_dout), .idle_o(idle)
    );

    // Multiplier stand-in: three ce-enabled stages, low PW bits of the product.
    always_comb prod = {{BW{1'b0}}, mul_din0} * {{AW{1'b0}}, mul_din1};
    always @(posedge clk) begin
        if (mul_ce) begin
            m0 <= prod[PW-1:0];
            m1 <= m0;
            m2 <= m1;
        end
    end
    assign mul_dout = m2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
        req_a[i*AW +: AW] = a;
        req_b[i*BW +: BW] = b;
    endtask

    initial begin
        #23;
        chk("reset_req_ready", 32'(req_ready), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_idle", 32'(idle), 1);
        chk("reset_mul_ce", 32'(mul_ce), 1);
        cyc();
        reset = 1'b0;
        cyc();

        // Fairness: all four held for 8 grants, responses in grant order
        for (int i = 0; i < NR; i++) set_op(i, AW'(i + 1), BW'(10));
        for (int k = 0; k < 11; k++) begin
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #4;
            if (k < 8) begin
                chk("fair_ready", 32'(req_ready), 32'(1 << (k % 4)));
                chk("fair_din0", 32'(mul_din0), 32'((k % 4) + 1));
            end
            if (k >= 3) begin
                chk("fair_rsp_valid", 32'(rsp_valid), 32'(1 << ((k - 3) % 4)));
                chk("fair_rsp_data", 32'(rsp_data), 32'(10 * (((k - 3) % 4) + 1)));
            end
            cyc();
        end
        #4;
        chk("fair_idle", 32'(idle), 1);
        cyc();

        // Single op on requester 0
        req_valid = 4'b0001; set_op(0, 5, 7);
        #4;
        chk("single_ready", 32'(req_ready), 32'b0001);
        chk("single_din1", 32'(mul_din1), 7);
        cyc();
        req_valid = '0;
        #4;
        chk("single_busy", 32'(idle), 0);
        chk("single_no_rsp", 32'(rsp_valid), 0);
        cyc(); cyc();
        #4;
        chk("single_rsp_valid", 32'(rsp_valid), 32'b0001);
        chk("single_rsp_data", 32'(rsp_data), 35);
        cyc();
        #4;
        chk("single_idle_after", 32'(idle), 1);
        chk("single_rsp_gone", 32'(rsp_valid), 0);
        cyc();

        // Truncation on requester 2 (pointer at 1)
        req_valid = 4'b0100; set_op(2, 1023, 2047);
        #4;
        chk("trunc_ready", 32'(req_ready), 32'b0100);
        cyc();
        req_valid = '0;
        cyc(); cyc();
        #4;
        chk("trunc_rsp_valid", 32'(rsp_valid), 32'b0100);
        chk("trunc_rsp_data", 32'(rsp_data), 1045505);
        cyc();

        // Pointer wrap: pointer at 3, requesters 3 and 0
        req_valid = 4'b1001; set_op(3, 2, 3); set_op(0, 4, 5);
        #4;
        chk("wrap_ready3", 32'(req_ready), 32'b1000);
        cyc();
        req_valid = 4'b0001;
        #4;
        chk("wrap_ready0", 32'(req_ready), 32'b0001);
        cyc();
        req_valid = '0;
        cyc();
        #4;
        chk("wrap_rsp3", 32'(rsp_valid), 32'b1000);
        chk("wrap_data3", 32'(rsp_data), 6);
        cyc();
        #4;
        chk("wrap_rsp0", 32'(rsp_valid), 32'b0001);
        chk("wrap_data0", 32'(rsp_data), 20);
        cyc();
        req_valid = 4'b0101; set_op(2, 3, 3);
        #4;
        chk("wrap_ptr_is_1", 32'(req_ready), 32'b0100);
        cyc();
        req_valid = '0;
        cyc(); cyc();
        #4;
        chk("wrap_rsp2", 32'(rsp_valid), 32'b0100);
        chk("wrap_data2", 32'(rsp_data), 9);
        cyc();

        // Backpressure on requester 1 with one op behind it and a waiting request
        rsp_ready = 4'b1101;
        req_valid = 4'b0010; set_op(1, 6, 7);
        #4;
        chk("bp_ready1", 32'(req_ready), 32'b0010);
        cyc();
        req_valid = 4'b0001; set_op(0, 3, 3);
        #4;
        chk("bp_ready0", 32'(req_ready), 32'b0001);
        cyc();
        req_valid = '0;
        cyc();
        req_valid = 4'b0100; set_op(2, 8, 8);
        for (int k = 0; k < 5; k++) begin
            #4;
            chk("bp_ce", 32'(mul_ce), 0);
            chk("bp_no_ready", 32'(req_ready), 0);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'b0010);
            chk("bp_rsp_data", 32'(rsp_data), 42);
            cyc();
        end
        rsp_ready = 4'b1111;
        #4;
        chk("bp_release_ce", 32'(mul_ce), 1);
        chk("bp_release_ready2", 32'(req_ready), 32'b0100);
        chk("bp_release_data", 32'(rsp_data), 42);
        cyc();
        req_valid = '0;
        #4;
        chk("bp_next_rsp0", 32'(rsp_valid), 32'b0001);
        chk("bp_next_data0", 32'(rsp_data), 9);
        cyc();
        #4;
        chk("bp_gap", 32'(rsp_valid), 0);
        cyc();
        #4;
        chk("bp_rsp2", 32'(rsp_valid), 32'b0100);
        chk("bp_data2", 32'(rsp_data), 64);
        cyc();
        #4;
        chk("bp_idle", 32'(idle), 1);
        cyc();

        // Reset mid-operation with two ops in flight
        req_valid = 4'b0011; set_op(0, 1, 1); set_op(1, 2, 2);
        #4;
        chk("rst_grant0", 32'(req_ready), 32'b0001);
        cyc();
        req_valid = 4'b0010;
        #4;
        chk("rst_grant1", 32'(req_ready), 32'b0010);
        cyc();
        req_valid = '0;
        cyc();
        #1;
        chk("rst_busy", 32'(idle), 0);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_rsp_drop", 32'(rsp_valid), 0);
        chk("rst_idle", 32'(idle), 1);
        #10;
        reset = 1'b0;
        cyc();
        for (int k = 0; k < 5; k++) begin
            #4;
            chk("rst_no_stale", 32'(rsp_valid), 0);
            cyc();
        end
        req_valid = 4'b0110;
        #4;
        chk("rst_ptr_zero", 32'(req_ready), 32'b0010);
        cyc();
        req_valid = '0;
        cyc();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
